// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: rank-level command scheduler.
// Grants at most one ACT/RD/WR/PRE/REF request per cycle across all banks,
// enforces tRRD/tCCD/tWTR/tRTW spacing and issues one registered DRAM
// command per cycle.
// Optional feature macro: SAL_TFAW_EN adds a four-activate (tFAW) window.
module sal_cmd_sched #(
    parameter int NUM_BANKS = 8,
    parameter int BA_W      = $clog2(NUM_BANKS),
    parameter int RA_W      = 16,
    parameter int CA_W      = 10,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 8,
    parameter int SEQ_W     = 16,
    parameter int T_W       = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [T_W-1:0]                   t_rrd_m1,
    input  logic [T_W-1:0]                   t_ccd_m1,
    input  logic [T_W-1:0]                   t_wtr_m1,
    input  logic [T_W-1:0]                   t_rtw_m1,
`ifdef SAL_TFAW_EN
    input  logic [T_W-1:0]                   t_faw_m1,
`endif
    input  logic [NUM_BANKS-1:0]             act_req_i,
    input  logic [NUM_BANKS-1:0]             rd_req_i,
    input  logic [NUM_BANKS-1:0]             wr_req_i,
    input  logic [NUM_BANKS-1:0]             pre_req_i,
    input  logic [NUM_BANKS-1:0]             ref_req_i,
    input  logic [NUM_BANKS-1:0][RA_W-1:0]   ra_i,
    input  logic [NUM_BANKS-1:0][CA_W-1:0]   ca_i,
    input  logic [NUM_BANKS-1:0][ID_W-1:0]   id_i,
    input  logic [NUM_BANKS-1:0][LEN_W-1:0]  len_i,
    input  logic [NUM_BANKS-1:0][SEQ_W-1:0]  seq_num_i,
    output logic [NUM_BANKS-1:0]             act_gnt_o,
    output logic [NUM_BANKS-1:0]             rd_gnt_o,
    output logic [NUM_BANKS-1:0]             wr_gnt_o,
    output logic [NUM_BANKS-1:0]             pre_gnt_o,
    output logic [NUM_BANKS-1:0]             ref_gnt_o,
    output logic                             cmd_valid_o,
    output logic [2:0]                       cmd_o,
    output logic [BA_W-1:0]                  ba_o,
    output logic [RA_W-1:0]                  ra_o,
    output logic [CA_W-1:0]                  ca_o,
    output logic [ID_W-1:0]                  id_o,
    output logic [LEN_W-1:0]                 len_o,
    output logic [SEQ_W-1:0]                 seq_num_o
);

    localparam int unsigned NB = NUM_BANKS;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    // Timing counters
    logic [T_W-1:0]  r_rrd_cnt;
    logic [T_W-1:0]  r_ccd_cnt;
    logic [T_W-1:0]  r_wtr_cnt;
    logic [T_W-1:0]  r_rtw_cnt;

    // Round-robin pointers, one per class (last granted bank)
    logic [BA_W-1:0] r_ptr_cas;
    logic [BA_W-1:0] r_ptr_act;
    logic [BA_W-1:0] r_ptr_pre;
    logic [BA_W-1:0] r_ptr_ref;

    logic                 w_rd_ok;
    logic                 w_wr_ok;
    logic                 w_act_ok;
    logic [NUM_BANKS-1:0] w_cas_elig;
    logic [NUM_BANKS-1:0] w_act_elig;
    logic [BA_W:0]        w_cas_pick;
    logic [BA_W:0]        w_act_pick;
    logic [BA_W:0]        w_pre_pick;
    logic [BA_W:0]        w_ref_pick;

    logic                 w_gnt;
    cmd_e                 w_cmd;
    logic [BA_W-1:0]      w_ba;
    logic                 w_gnt_act;
    logic                 w_gnt_rd;
    logic                 w_gnt_wr;

    // Round-robin search starting at ptr+1; returns {found, bank}
    function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                              input logic [BA_W-1:0]      ptr);
        logic            found;
        logic [BA_W-1:0] idx;
        int unsigned     b;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NB; k++) begin
            b = 32'(ptr) + k;
            if (b >= NB) begin
                b = b - NB;
            end
            if (!found && req[b]) begin
                found = 1'b1;
                idx   = b[BA_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] x);
        return (x == '0) ? x : x - 1'b1;
    endfunction

`ifdef SAL_TFAW_EN
    logic [3:0][T_W-1:0] r_faw_cnt;
    logic                w_faw_ok;
    logic [1:0]          w_faw_slot;

    // Find a free activate-window slot; any free slot is interchangeable
    always_comb begin
        w_faw_ok   = 1'b0;
        w_faw_slot = '0;
        for (int unsigned s = 0; s < 4; s++) begin
            if (!w_faw_ok && (r_faw_cnt[s] == '0)) begin
                w_faw_ok   = 1'b1;
                w_faw_slot = s[1:0];
            end
        end
    end

    // Activate-window countdowns: load on ACT grant, otherwise count down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_faw_cnt <= '0;
        end else begin
            for (int unsigned s = 0; s < 4; s++) begin
                if (w_gnt_act && (w_faw_slot == s[1:0])) begin
                    r_faw_cnt[s] <= t_faw_m1;
                end else begin
                    r_faw_cnt[s] <= dec_sat(r_faw_cnt[s]);
                end
            end
        end
    end
`endif

    // Per-class eligibility from the timing counters
    always_comb begin
        w_rd_ok    = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
        w_wr_ok    = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
`ifdef SAL_TFAW_EN
        w_act_ok   = (r_rrd_cnt == '0) && w_faw_ok;
`else
        w_act_ok   = (r_rrd_cnt == '0);
`endif
        w_cas_elig = (rd_req_i & {NUM_BANKS{w_rd_ok}}) | (wr_req_i & {NUM_BANKS{w_wr_ok}});
        w_act_elig = act_req_i & {NUM_BANKS{w_act_ok}};
        w_cas_pick = rr_pick(w_cas_elig, r_ptr_cas);
        w_act_pick = rr_pick(w_act_elig, r_ptr_act);
        w_pre_pick = rr_pick(pre_req_i, r_ptr_pre);
        w_ref_pick = rr_pick(ref_req_i, r_ptr_ref);
    end

    // Class priority CAS > ACT > PRE > REF; a bank eligible for both RD and WR issues RD
    always_comb begin
        w_gnt = 1'b0;
        w_cmd = CMD_NOP;
        w_ba  = '0;
        if (rst_n) begin
            if (w_cas_pick[BA_W]) begin
                w_gnt = 1'b1;
                w_ba  = w_cas_pick[BA_W-1:0];
                w_cmd = (rd_req_i[w_ba] && w_rd_ok) ? CMD_RD : CMD_WR;
            end else if (w_act_pick[BA_W]) begin
                w_gnt = 1'b1;
                w_ba  = w_act_pick[BA_W-1:0];
                w_cmd = CMD_ACT;
            end else if (w_pre_pick[BA_W]) begin
                w_gnt = 1'b1;
                w_ba  = w_pre_pick[BA_W-1:0];
                w_cmd = CMD_PRE;
            end else if (w_ref_pick[BA_W]) begin
                w_gnt = 1'b1;
                w_ba  = w_ref_pick[BA_W-1:0];
                w_cmd = CMD_REF;
            end
        end
        w_gnt_act = w_gnt && (w_cmd == CMD_ACT);
        w_gnt_rd  = w_gnt && (w_cmd == CMD_RD);
        w_gnt_wr  = w_gnt && (w_cmd == CMD_WR);
    end

    // Decode the single winner onto the per-type grant vectors
    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        if (w_gnt) begin
            case (w_cmd)
                CMD_ACT: act_gnt_o[w_ba] = 1'b1;
                CMD_RD:  rd_gnt_o[w_ba]  = 1'b1;
                CMD_WR:  wr_gnt_o[w_ba]  = 1'b1;
                CMD_PRE: pre_gnt_o[w_ba] = 1'b1;
                CMD_REF: ref_gnt_o[w_ba] = 1'b1;
                default: ;
            endcase
        end
    end

    // Inter-bank timing counters: load on the granting cycle, then count down to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rrd_cnt <= '0;
            r_ccd_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
        end else begin
            r_rrd_cnt <= w_gnt_act               ? t_rrd_m1 : dec_sat(r_rrd_cnt);
            r_ccd_cnt <= (w_gnt_rd || w_gnt_wr)  ? t_ccd_m1 : dec_sat(r_ccd_cnt);
            r_wtr_cnt <= w_gnt_wr                ? t_wtr_m1 : dec_sat(r_wtr_cnt);
            r_rtw_cnt <= w_gnt_rd                ? t_rtw_m1 : dec_sat(r_rtw_cnt);
        end
    end

    // Round-robin pointers follow the last granted bank of their class
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr_cas <= BA_W'(NUM_BANKS - 1);
            r_ptr_act <= BA_W'(NUM_BANKS - 1);
            r_ptr_pre <= BA_W'(NUM_BANKS - 1);
            r_ptr_ref <= BA_W'(NUM_BANKS - 1);
        end else if (w_gnt) begin
            case (w_cmd)
                CMD_RD, CMD_WR: r_ptr_cas <= w_ba;
                CMD_ACT:        r_ptr_act <= w_ba;
                CMD_PRE:        r_ptr_pre <= w_ba;
                CMD_REF:        r_ptr_ref <= w_ba;
                default: ;
            endcase
        end
    end

    // Registered command path; fields hold when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            ba_o        <= '0;
            ra_o        <= '0;
            ca_o        <= '0;
            id_o        <= '0;
            len_o       <= '0;
            seq_num_o   <= '0;
        end else if (w_gnt) begin
            cmd_valid_o <= 1'b1;
            cmd_o       <= w_cmd;
            ba_o        <= w_ba;
            ra_o        <= ra_i[w_ba];
            ca_o        <= ca_i[w_ba];
            id_o        <= id_i[w_ba];
            len_o       <= len_i[w_ba];
            seq_num_o   <= seq_num_i[w_ba];
        end else begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Testbench for sal_cmd_sched: directed scenarios plus randomized traffic
// checked against a cycle-history reference model.
module tb_sal_cmd_sched;

    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [5:0]           tr, tc, tw, tt, tf;
    logic [NB-1:0]        act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB-1:0][15:0]  ra;
    logic [NB-1:0][9:0]   ca;
    logic [NB-1:0][3:0]   id;
    logic [NB-1:0][7:0]   len;
    logic [NB-1:0][15:0]  seq;
    logic [NB-1:0]        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic                 cmd_valid;
    logic [2:0]           cmd;
    logic [2:0]           ba;
    logic [15:0]          ra_o;
    logic [9:0]           ca_o;
    logic [3:0]           id_o;
    logic [7:0]           len_o;
    logic [15:0]          seq_o;

    sal_cmd_sched #(.NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rrd_m1(tr), .t_ccd_m1(tc), .t_wtr_m1(tw), .t_rtw_m1(tt),
`ifdef SAL_TFAW_EN
        .t_faw_m1(tf),
`endif
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len), .seq_num_i(seq),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .ba_o(ba),
        .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o), .seq_num_o(seq_o)
    );

    logic [39:0] gnt_all;
    logic [60:0] out_all;
    assign gnt_all = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
    assign out_all = {cmd_valid, cmd, ba, ra_o, ca_o, id_o, len_o, seq_o};

    int checks = 0;
    int passes = 0;

    // Reference model: remembers when each command kind was last granted
    int          cyc;
    int          last_act, last_cas, last_rd, last_wr;
    int          act_hist[$];
    int          ptr[4];            // 0 CAS, 1 ACT, 2 PRE, 3 REF
    logic [39:0] exp_gnt;
    logic [60:0] exp_out;

    task automatic model_reset();
        last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
        act_hist.delete();
        for (int i = 0; i < 4; i++) ptr[i] = NB - 1;
        exp_out = '0;
    endtask

    function automatic int rr(input logic [NB-1:0] req, input int p);
        for (int k = 1; k <= NB; k++) begin
            if (req[(p + k) % NB]) return (p + k) % NB;
        end
        return -1;
    endfunction

    task automatic model_grant();
        bit aok, rok, wok;
        int n, b;
        logic [NB-1:0] cas_e, act_e;
        exp_gnt = '0;
        if (!rst_n) return;
        aok = (cyc - last_act) > int'(tr);
`ifdef SAL_TFAW_EN
        n = 0;
        foreach (act_hist[i]) if (cyc - act_hist[i] <= int'(tf)) n++;
        aok = aok && (n < 4);
`endif
        rok = ((cyc - last_cas) > int'(tc)) && ((cyc - last_wr) > int'(tw));
        wok = ((cyc - last_cas) > int'(tc)) && ((cyc - last_rd) > int'(tt));
        cas_e = (rok ? rd_req : '0) | (wok ? wr_req : '0);
        act_e = aok ? act_req : '0;
        if (cas_e != 0) begin
            b = rr(cas_e, ptr[0]);
            if (rok && rd_req[b]) exp_gnt[24 + b] = 1'b1;
            else                  exp_gnt[16 + b] = 1'b1;
        end else if (act_e != 0) begin
            exp_gnt[32 + rr(act_e, ptr[1])] = 1'b1;
        end else if (pre_req != 0) begin
            exp_gnt[8 + rr(pre_req, ptr[2])] = 1'b1;
        end else if (ref_req != 0) begin
            exp_gnt[rr(ref_req, ptr[3])] = 1'b1;
        end
    endtask

    task automatic model_commit();
        int j, cls, b;
        logic [2:0] c;
        if (!rst_n) begin
            model_reset();
        end else if (exp_gnt != 0) begin
            j = 0;
            for (int i = 0; i < 40; i++) if (exp_gnt[i]) j = i;
            cls = j / 8;
            b   = j % 8;
            case (cls)
                4: begin c = 3'd1; last_act = cyc; act_hist.push_back(cyc); ptr[1] = b; end
                3: begin c = 3'd2; last_rd = cyc; last_cas = cyc; ptr[0] = b; end
                2: begin c = 3'd3; last_wr = cyc; last_cas = cyc; ptr[0] = b; end
                1: begin c = 3'd4; ptr[2] = b; end
                default: begin c = 3'd5; ptr[3] = b; end
            endcase
            exp_out = {1'b1, c, 3'(b), ra[b], ca[b], id[b], len[b], seq[b]};
        end else begin
            exp_out[60:57] = 4'b0000;
        end
        while (act_hist.size() > 0 && cyc - act_hist[0] > 100) void'(act_hist.pop_front());
        cyc++;
    endtask

    task automatic clear_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NB; i++) begin
            ra[i] = 16'($urandom); ca[i] = 10'($urandom); id[i] = 4'($urandom);
            len[i] = 8'($urandom); seq[i] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
        @(negedge clk);
        checks++;
        if (gnt_all !== 40'h0) $display("FAIL reset_gnt0 got %h exp 0", gnt_all); else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({gnt_all, out_all} !== 101'h0) $display("FAIL reset_state got %h/%h exp 0", gnt_all, out_all); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_reqs();
    endtask

    task automatic test_single_rd();
        logic [9:0] ca0;
        logic [3:0] id0;
        tr = 0; tc = 0; tw = 0; tt = 0; tf = 0;
        do_reset();
        rand_fields();
        ca0 = ca[0]; id0 = id[0];
        rd_req = 8'h01;
        @(negedge clk);
        checks++;
        if (gnt_all !== {8'h00, 8'h01, 24'h0}) $display("FAIL single_rd_gnt got %h", gnt_all); else passes++;
        @(posedge clk); #1;
        rd_req = '0;
        rand_fields();
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd, ba, ca_o, id_o} !== {1'b1, 3'd2, 3'd0, ca0, id0})
            $display("FAIL single_rd_cmd got %b %0d %0d %h %h exp 1 2 0 %h %h", cmd_valid, cmd, ba, ca_o, id_o, ca0, id0);
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd, ca_o} !== {1'b0, 3'd0, ca0})
            $display("FAIL idle_hold got %b %0d %h exp 0 0 %h", cmd_valid, cmd, ca_o, ca0);
        else passes++;
    endtask

    task automatic test_rrd();
        logic [NB-1:0] e;
        tr = 3; tc = 0; tw = 0; tt = 0; tf = 0;
        do_reset();
        act_req = '1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            e = (c % 4 == 0) ? NB'(1 << (c / 4)) : '0;
            checks++;
            if (act_gnt !== e) $display("FAIL rrd_spacing c=%0d got %h exp %h", c, act_gnt, e); else passes++;
            @(posedge clk); #1;
        end
        clear_reqs();
    endtask

    task automatic test_wtr();
        logic [NB-1:0] e;
        tr = 0; tc = 1; tw = 5; tt = 0; tf = 0;
        do_reset();
        wr_req = 8'h04;
        @(negedge clk);
        checks++;
        if (wr_gnt !== 8'h04) $display("FAIL wtr_wr got %h exp 04", wr_gnt); else passes++;
        @(posedge clk); #1;
        wr_req = '0;
        rd_req = 8'h08;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            e = (c == 6) ? 8'h08 : 8'h00;
            checks++;
            if (rd_gnt !== e) $display("FAIL wtr_rd c=%0d got %h exp %h", c, rd_gnt, e); else passes++;
            @(posedge clk); #1;
        end
        clear_reqs();
    endtask

    task automatic test_priority();
        tr = 0; tc = 0; tw = 0; tt = 0; tf = 0;
        do_reset();
        act_req = 8'h10; rd_req = 8'h01; pre_req = 8'h80;
        @(negedge clk);
        checks++;
        if (gnt_all !== {8'h00, 8'h01, 24'h0}) $display("FAIL prio_c0 got %h", gnt_all); else passes++;
        @(posedge clk); #1;
        rd_req = '0;
        @(negedge clk);
        checks++;
        if ({gnt_all, cmd} !== {8'h10, 32'h0, 3'd2}) $display("FAIL prio_c1 got %h cmd %0d", gnt_all, cmd); else passes++;
        @(posedge clk); #1;
        act_req = '0;
        @(negedge clk);
        checks++;
        if ({gnt_all, cmd} !== {24'h0, 8'h80, 8'h00, 3'd1}) $display("FAIL prio_c2 got %h cmd %0d", gnt_all, cmd); else passes++;
        @(posedge clk); #1;
        pre_req = '0;
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd, ba} !== {1'b1, 3'd4, 3'd7}) $display("FAIL prio_pre got %b %0d %0d exp 1 4 7", cmd_valid, cmd, ba); else passes++;
    endtask

`ifdef SAL_TFAW_EN
    task automatic test_tfaw();
        logic [NB-1:0] e;
        int g;
        tr = 0; tc = 0; tw = 0; tt = 0; tf = 15;
        do_reset();
        act_req = '1;
        g = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e = (c < 4 || c >= 16) ? NB'(1 << g) : '0;
            if (e != 0) g++;
            checks++;
            if (act_gnt !== e) $display("FAIL tfaw c=%0d got %h exp %h", c, act_gnt, e); else passes++;
            @(posedge clk); #1;
        end
        clear_reqs();
    endtask
`endif

    task automatic test_reset_mid();
        tr = 3; tc = 0; tw = 0; tt = 0; tf = 0;
        do_reset();
        act_req = '1;
        @(negedge clk);
        checks++;
        if (act_gnt !== 8'h01) $display("FAIL rstmid_first got %h exp 01", act_gnt); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_all !== 40'h0) $display("FAIL rstmid_gnt got %h exp 0", gnt_all); else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({gnt_all, out_all} !== 101'h0) $display("FAIL rstmid_state got %h/%h exp 0", gnt_all, out_all); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (act_gnt !== 8'h01) $display("FAIL rstmid_after got %h exp 01", act_gnt); else passes++;
        @(posedge clk); #1;
        clear_reqs();
    endtask

    task automatic test_random(input int unsigned seed_sel);
        cyc = 0;
        model_reset();
        case (seed_sel)
            0: begin tr = 0; tc = 0; tw = 0; tt = 0; tf = 3; end
            1: begin tr = 3; tc = 1; tw = 5; tt = 2; tf = 12; end
            default: begin
                tr = 6'($urandom_range(0, 4)); tc = 6'($urandom_range(0, 4));
                tw = 6'($urandom_range(0, 6)); tt = 6'($urandom_range(0, 4));
                tf = 6'($urandom_range(4, 15));
            end
        endcase
        for (int c = 0; c < 300; c++) begin
            rst_n   = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            act_req = NB'($urandom) & NB'($urandom);
            rd_req  = NB'($urandom) & NB'($urandom) & NB'($urandom);
            wr_req  = NB'($urandom) & NB'($urandom) & NB'($urandom);
            pre_req = NB'($urandom) & NB'($urandom);
            ref_req = NB'($urandom) & NB'($urandom);
            rand_fields();
            @(negedge clk);
            model_grant();
            checks++;
            if (gnt_all !== exp_gnt) $display("FAIL rand%0d_gnt c=%0d got %h exp %h", seed_sel, c, gnt_all, exp_gnt); else passes++;
            if (c >= 1) begin
                checks++;
                if (out_all !== exp_out) $display("FAIL rand%0d_cmd c=%0d got %h exp %h", seed_sel, c, out_all, exp_out); else passes++;
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        rst_n = 1'b1;
        clear_reqs();
    endtask

    initial begin
        rst_n = 1'b0;
        tr = 0; tc = 0; tw = 0; tt = 0; tf = 0;
        clear_reqs();
        rand_fields();
        #1;
        test_reset();
        test_single_rd();
        test_rrd();
        test_wtr();
        test_priority();
`ifdef SAL_TFAW_EN
        test_tfaw();
`endif
        test_reset_mid();
        for (int unsigned s = 0; s < 4; s++) test_random(s);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
